uart_input_protocol_ctrl: RTL

- Byte-stream protocol controller for the Tang Nano 9K stream interface. It sits between the UART receiver and the per-channel accelerator input FIFOs.
- Decodes command bytes into a software reset pulse, a sticky start flag, and data words.
- Data words are assembled little-endian from ACC_DATA_WIDTH/8 bytes and written into one of NUM_CHANNELS input FIFOs.
- Parametrised in channel count and data width. Adds overflow and protocol-error detection.

---
 rtl/uart_input_protocol_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_input_protocol_ctrl.sv
// uart_input_protocol_ctrl: byte-stream command decoder between the UART
// receiver and the per-channel accelerator input FIFOs.
//   Opcodes (IDLE only): 0x00 NOP, 0x01 RESET, 0x02 START, 0x03 DATA.
//   DATA frame: 0x03, channel byte, BYTES_PER_WORD payload bytes (little-endian).
// Optional build macro: UART_INPUT_PROTOCOL_CTRL_TIMEOUT_EN adds an
// inter-byte timeout (parameter TIMEOUT_CYCLES) that aborts a stalled frame.
module uart_input_protocol_ctrl #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned ACC_DATA_WIDTH = 32
`ifdef UART_INPUT_PROTOCOL_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 270000
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_data_valid,
    input  logic [7:0]                rx_data,
    input  logic [NUM_CHANNELS-1:0]   fifo_full,
    output logic [NUM_CHANNELS-1:0]   fifo_wr_en,
    output logic [ACC_DATA_WIDTH-1:0] fifo_wr_data,
    output logic                      sw_rst,
    output logic                      start,
    output logic                      busy,
    output logic                      overflow,
    output logic                      proto_err
);

    localparam int unsigned BYTES_PER_WORD = ACC_DATA_WIDTH / 8;
    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_RESET = 8'h01;
    localparam logic [7:0] OP_START = 8'h02;
    localparam logic [7:0] OP_DATA  = 8'h03;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CHAN    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]                state_q,     state_d;
    logic [CNT_W-1:0]          cnt_q,       cnt_d;
    logic [CH_W-1:0]           ch_q,        ch_d;
    logic [ACC_DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [NUM_CHANNELS-1:0]   wr_en_q,     wr_en_d;
    logic [ACC_DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic                      sw_rst_q,    sw_rst_d;
    logic                      start_q,     start_d;
    logic                      busy_q,      busy_d;
    logic                      overflow_q,  overflow_d;
    logic                      proto_err_q, proto_err_d;

`ifdef UART_INPUT_PROTOCOL_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            shreg_q     <= '0;
            wr_en_q     <= '0;
            wr_data_q   <= '0;
            sw_rst_q    <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            shreg_q     <= shreg_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            sw_rst_q    <= sw_rst_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef UART_INPUT_PROTOCOL_CTRL_TIMEOUT_EN
    // Inter-byte idle counter, only meaningful while a frame is open
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Next-state: opcode decode, frame sequencing and word write-out
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        shreg_d     = shreg_q;
        wr_en_d     = '0;
        wr_data_d   = wr_data_q;
        sw_rst_d    = 1'b0;
        start_d     = start_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;

        if (rx_data_valid) begin
            case (state_q)
                ST_IDLE: begin
                    case (rx_data)
                        OP_NOP:   ;
                        OP_RESET: sw_rst_d = 1'b1;
                        OP_START: start_d  = 1'b1;
                        OP_DATA:  state_d  = ST_CHAN;
                        default:  proto_err_d = 1'b1;
                    endcase
                end

                ST_CHAN: begin
                    cnt_d = '0;
                    if (32'(rx_data) < NUM_CHANNELS) begin
                        ch_d    = CH_W'(rx_data);
                        state_d = ST_PAYLOAD;
                    end else begin
                        proto_err_d = 1'b1;
                        state_d     = ST_DISCARD;
                    end
                end

                ST_PAYLOAD: begin
                    shreg_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        // FIFO full is sampled with the final byte; a full FIFO loses the word
                        if (fifo_full[ch_q]) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en_d   = NUM_CHANNELS'(1) << ch_q;
                            wr_data_d = shreg_d;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_DISCARD: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end

`ifdef UART_INPUT_PROTOCOL_CTRL_TIMEOUT_EN
        // Abort a stalled frame: drop the partial word without writing
        to_cnt_d = '0;
        if (!rx_data_valid && (state_q != ST_IDLE)) begin
            if (to_cnt_q == TO_LAST) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                proto_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign sw_rst       = sw_rst_q;
    assign start        = start_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign proto_err    = proto_err_q;

endmodule
